// File: rtl/comparator_serial_n_if.sv
// Handshake and operand/result bundle for the bit-serial magnitude comparator.
interface comparator_serial_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/comparator_serial_n.sv
// Bit-serial MSB-first comparator: one bit pair per clock, optional early exit on first difference.
module comparator_serial_n #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    comparator_serial_n_if.slave bus
);
    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic             found_q, found_d;
    logic             res_gt_q, res_gt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic bit_diff;
    logic bit_gt;

    // When bits differ, a=1 means A is larger, except the sign bit in signed mode.
    assign bit_diff = a_q[idx_q] ^ b_q[idx_q];
    assign bit_gt   = a_q[idx_q] ^ (signed_q && (idx_q == IdxMax));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        found_d  = found_q;
        res_gt_d = res_gt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    signed_d = bus.signed_mode;
                    idx_d    = IdxMax;
                    found_d  = 1'b0;
                    res_gt_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StCmp;
                end
            end
            StCmp: begin
                if (EARLY_EXIT && bit_diff) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    gt_d    = bit_gt;
                    lt_d    = ~bit_gt;
                    eq_d    = 1'b0;
                end else if (idx_q == '0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    if (found_q) begin
                        gt_d = res_gt_q;
                        lt_d = ~res_gt_q;
                        eq_d = 1'b0;
                    end else if (bit_diff) begin
                        gt_d = bit_gt;
                        lt_d = ~bit_gt;
                        eq_d = 1'b0;
                    end else begin
                        gt_d = 1'b0;
                        lt_d = 1'b0;
                        eq_d = 1'b1;
                    end
                end else begin
                    // Full-scan mode keeps only the most significant difference.
                    if (bit_diff && !found_q) begin
                        found_d  = 1'b1;
                        res_gt_d = bit_gt;
                    end
                    idx_d  = idx_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= IdxMax;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            found_q  <= 1'b0;
            res_gt_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            found_q  <= found_d;
            res_gt_q <= res_gt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;
endmodule

// File: tb/tb_comparator_serial_n.sv
// Directed bench: early-exit and full-scan comparators, WIDTH=8, sharing one stimulus sequence.
module tb_comparator_serial_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic start_t = 1'b0;
    logic [7:0] a_t = '0;
    logic [7:0] b_t = '0;
    logic sm_t = 1'b0;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] ResGt = 3'b100;
    localparam logic [2:0] ResEq = 3'b010;
    localparam logic [2:0] ResLt = 3'b001;

    always #5 clk = ~clk;

    comparator_serial_n_if #(.WIDTH(8)) if_e ();
    comparator_serial_n_if #(.WIDTH(8)) if_f ();

    assign if_e.start       = start_t & ~sel;
    assign if_f.start       = start_t & sel;
    assign if_e.a           = a_t;
    assign if_f.a           = a_t;
    assign if_e.b           = b_t;
    assign if_f.b           = b_t;
    assign if_e.signed_mode = sm_t;
    assign if_f.signed_mode = sm_t;

    comparator_serial_n #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_e.slave)
    );

    comparator_serial_n #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_f.slave)
    );

    logic       busy_m;
    logic       done_m;
    logic [2:0] res_m;
    assign busy_m = sel ? if_f.busy : if_e.busy;
    assign done_m = sel ? if_f.done : if_e.done;
    assign res_m  = sel ? {if_f.gt, if_f.eq, if_f.lt} : {if_e.gt, if_e.eq, if_e.lt};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic sm);
        a_t = av;
        b_t = bv;
        sm_t = sm;
        start_t = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_t = 1'b0;
    endtask

    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_m) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic sm, input int exp_lat, input logic [2:0] exp_res);
        int lat;
        accept(av, bv, sm);
        check({tag, "_busy"}, 32'(busy_m), 32'd1);
        wait_done(20, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(res_m), 32'(exp_res));
        check({tag, "_busy_done"}, 32'(busy_m), 32'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        int first;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_e", 32'({if_e.busy, if_e.done, if_e.gt, if_e.eq, if_e.lt}), 32'd0);
        check("reset_f", 32'({if_f.busy, if_f.done, if_f.gt, if_f.eq, if_f.lt}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b0;
        run("eq_a5", 8'hA5, 8'hA5, 1'b0, 8, ResEq);
        run("u_80_7f", 8'h80, 8'h7F, 1'b0, 1, ResGt);
        run("s_80_7f", 8'h80, 8'h7F, 1'b1, 1, ResLt);
        run("s_ff_01", 8'hFF, 8'h01, 1'b1, 1, ResLt);
        run("s_fe_ff", 8'hFE, 8'hFF, 1'b1, 8, ResLt);
        run("u_10_18", 8'h10, 8'h18, 1'b0, 5, ResLt);

        // Second start during CMP, with new operands, must be ignored.
        accept(8'h03, 8'h02, 1'b0);
        ndone = 0;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                start_t = 1'b1;
                a_t = 8'h00;
                b_t = 8'hFF;
            end
            @(posedge clk);
            @(negedge clk);
            start_t = 1'b0;
            if (done_m) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        check("ign_lat", 32'(first), 32'd8);
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_res", 32'(res_m), 32'(ResGt));

        // Reset at cycle 3 of a compare, with start also high.
        accept(8'hA5, 8'hA5, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start_t = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid", 32'({busy_m, done_m, res_m}), 32'd0);
        rst_n = 1'b1;
        start_t = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_m) ndone++;
        end
        check("rst_ndone", 32'(ndone), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        run("post_rst", 8'h01, 8'h02, 1'b0, 7, ResLt);

        // Full-scan instance: MSB difference wins over bit-0 difference.
        sel = 1'b1;
        accept(8'h80, 8'h01, 1'b0);
        wait_done(20, lat);
        check("full_lat", 32'(lat), 32'd8);
        check("full_res", 32'(res_m), 32'(ResGt));
        check("full_busy_done", 32'(busy_m), 32'd0);
        // Back-to-back: start held in the DONE cycle.
        accept(8'h01, 8'h80, 1'b0);
        check("b2b_busy", 32'(busy_m), 32'd1);
        check("b2b_hold", 32'(res_m), 32'(ResGt));
        wait_done(20, lat);
        check("b2b_lat", 32'(lat), 32'd8);
        check("b2b_res", 32'(res_m), 32'(ResLt));
        run("full_s80", 8'h80, 8'h7F, 1'b1, 8, ResLt);
        run("full_eq", 8'h3C, 8'h3C, 1'b1, 8, ResEq);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comparator_serial_n.md
COMPARATOR_SERIAL_N -- requirements
Module: comparator_serial_n

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits (legal range 2..64).
REQ-002 SHALL provide parameter EARLY_EXIT, default 1, where 1 means stop at the first differing bit and 0 means always scan all WIDTH bits.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 start  input  1  request to begin a comparison.
REQ-007 a  input  WIDTH  operand A, sampled when start is accepted.
REQ-008 b  input  WIDTH  operand B, sampled when start is accepted.
REQ-009 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare; sampled when start is accepted.
REQ-010 busy  output  1  high while a comparison is in progress.
REQ-011 done  output  1  one-cycle pulse; gt/eq/lt are valid from this cycle onward.
REQ-012 gt  output  1  A > B for the last completed comparison.
REQ-013 eq  output  1  A == B for the last completed comparison.
REQ-014 lt  output  1  A < B for the last completed comparison.

Function
REQ-015 SHALL implement FSM states IDLE, CMP and DONE, with all outputs registered.
REQ-016 start SHALL be accepted only in IDLE or DONE, and ignored while in CMP.
REQ-017 On acceptance: capture a, b and signed_mode; set bit index to WIDTH-1; enter CMP; assert busy from the next cycle.
REQ-018 Each clock edge in CMP SHALL examine exactly one bit pair, MSB first, at the current index.
REQ-019 Unsigned compare, first differing bit: a=1 and b=0 gives gt; a=0 and b=1 gives lt.
REQ-020 Signed compare: at index WIDTH-1 the sense SHALL be inverted (a=1, b=0 gives lt); all lower bits use the unsigned rule.
REQ-021 With EARLY_EXIT=1, the first differing bit SHALL commit the result and move to DONE on that same edge.
REQ-022 With EARLY_EXIT=0, the first differing bit SHALL be latched internally; later differences SHALL NOT overwrite it; scanning continues down to index 0.
REQ-023 If no bits differ through index 0, the result SHALL be eq.
REQ-024 Latency: with start accepted at edge 0, the decision made at edge k (k = WIDTH - index) SHALL raise done in the cycle after edge k.
REQ-025 Worst-case latency SHALL be WIDTH cycles; it is always WIDTH cycles when EARLY_EXIT=0.
REQ-026 DONE SHALL last exactly one cycle, then go to IDLE, or to CMP if start is asserted in that DONE cycle (back-to-back operation).
REQ-027 busy SHALL be high only in CMP, and SHALL be low in the DONE cycle.
REQ-028 gt/eq/lt SHALL update only on the edge entering DONE, and hold until the next completion.
REQ-029 After the first completion, exactly one of gt/eq/lt SHALL be high.
REQ-030 Changes on a, b or signed_mode after acceptance SHALL NOT affect the result in progress.

Reset
REQ-031 While rst_n=0 at a rising edge: state goes to IDLE; busy, done, gt, eq and lt go to 0; bit index goes to WIDTH-1.
REQ-032 Reset asserted during CMP SHALL abort the operation with no done pulse; start SHALL be ignored in any cycle where rst_n=0.

Verification (WIDTH=8)
REQ-033 Unsigned, EARLY_EXIT=1, a=0xA5, b=0xA5 -> done 8 cycles after accept, eq=1, gt=lt=0.
REQ-034 Unsigned, a=0x80, b=0x7F -> done 1 cycle after accept, gt=1.
REQ-035 Signed, a=0x80 (-128), b=0x7F (+127) -> done 1 cycle after accept, lt=1.
REQ-036 Accept a=0x03, b=0x02, then pulse start again at cycle 3 -> second start ignored; done at cycle 8 with gt=1; exactly one done pulse.
REQ-037 rst_n=0 at cycle 3 of a compare -> busy=done=gt=eq=lt=0, no done pulse; a new compare afterwards completes correctly.
REQ-038 EARLY_EXIT=0, a=0x80, b=0x01 -> done exactly 8 cycles after accept, gt=1 (MSB difference kept over the bit-0 difference); start held in the DONE cycle starts the next compare immediately.
